uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning tick pulses per bit period (even, >=4).
REQ-002 SHALL have parameter PARITY_EN, default 0, meaning 1 = one parity bit between the data bits and the stop bit.
REQ-003 SHALL have parameter PARITY_ODD, default 0, meaning 1 = odd parity, 0 = even parity.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rx_in  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port tick  input  1  oversample enable, one-clk pulse, OVERSAMPLE per bit.
REQ-008 SHALL have port shift  output  1  one-clk pulse commanding the downstream shift register to capture rx_bit.
REQ-009 SHALL have port rx_bit  output  1  sampled data bit, valid while shift=1.
REQ-010 SHALL have port rx_busy  output  1  high from start-bit detection until return to IDLE.
REQ-011 SHALL have port rx_done  output  1  one-clk pulse at end of every completed frame.
REQ-012 SHALL have port frame_err  output  1  stop bit sampled low in last frame; held until next rx_done.
REQ-013 SHALL have port parity_err  output  1  parity mismatch in last frame; held until next rx_done; always 0 when PARITY_EN=0.

Function
REQ-014 SHALL synchronise rx_in through two flops (rx_s) before any use.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK; all actions below happen only on clk cycles with tick=1.
REQ-016 IDLE: rx_s=0 -> START, tick_cnt=0; otherwise stay.
REQ-017 START: tick_cnt increments; at tick_cnt=OVERSAMPLE/2-1 (mid start bit) rx_s=0 -> DATA with tick_cnt=0, bit_cnt=0; rx_s=1 -> IDLE (glitch rejected, no outputs pulse).
REQ-018 DATA: at tick_cnt=OVERSAMPLE-1, SHALL register shift=1 and rx_bit=rx_s for exactly one clk, fold rx_s into the parity accumulator, and clear tick_cnt.
REQ-019 DATA: after the 8th sample (bit_cnt=7), SHALL go to PARITY if PARITY_EN=1, else to STOP; otherwise bit_cnt increments.
REQ-020 Data bits SHALL be delivered LSB first, exactly 8 shift pulses per accepted frame, none in any other state.
REQ-021 PARITY: at tick_cnt=OVERSAMPLE-1, SHALL compute the error as XOR of data bits, parity bit, and PARITY_ODD (nonzero = error), then go to STOP; no shift pulse.
REQ-022 STOP: at tick_cnt=OVERSAMPLE-1, SHALL pulse rx_done one clk later and update frame_err=~rx_s and parity_err together with rx_done.
REQ-023 STOP with rx_s=1 -> IDLE; with rx_s=0 -> BREAK.
REQ-024 BREAK: SHALL stay until rx_s=1, then -> IDLE; no start detection while in BREAK.
REQ-025 rx_done SHALL never coincide with shift; the last shift SHALL precede rx_done by at least OVERSAMPLE ticks.
REQ-026 rx_busy SHALL be 1 in START, DATA, PARITY, STOP, and 0 in IDLE and BREAK.
REQ-027 Cycles with tick=0 SHALL hold all counters and state; shift and rx_done SHALL deassert after their single clk.

Reset
REQ-028 reset=0 SHALL immediately force IDLE, all counters to 0, synchroniser flops to 1, and shift, rx_bit, rx_busy, rx_done, frame_err, parity_err to 0.
REQ-029 Reset asserted mid-frame SHALL abort without rx_done, and a partial frame SHALL not be resumed.
REQ-030 Reset SHALL take priority over a simultaneous tick.

Verification
REQ-031 OVERSAMPLE=16, tick every clk, frame 0xA5 with stop=1 -> 8 shift pulses with rx_bit 1,0,1,0,0,1,0,1 spaced 16 clk apart, one rx_done, frame_err=0.
REQ-032 rx_in low for 5 ticks, then high -> return to IDLE, no shift, no rx_done, rx_busy drops.
REQ-033 0x3C with stop=0, line held low for 40 ticks then high -> rx_done with frame_err=1, no new frame until the line goes high, next 0x55 frame clears frame_err.
REQ-034 PARITY_EN=1, even parity, 0xA5 with parity bit 1 -> parity_err=1; same frame with parity bit 0 -> parity_err=0.
REQ-035 reset pulsed after the 4th shift of a frame -> all outputs 0 at once, no rx_done; next full frame 0x0F -> 8 shifts, correct bits.
REQ-036 Two back-to-back frames 0x81, 0x7E with tick every 3 clk -> 16 shifts, 2 rx_done pulses, no missed start bit.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- oversampled UART receive controller.
//
// Watches an asynchronous serial line and detects start bits. It samples each
// data bit at the middle of its bit period and tells a downstream shift
// register when to capture the bit. At the end of each frame it reports
// framing and parity status. All frame timing advances only on cycles where
// tick=1; each bit period is OVERSAMPLE ticks long.
//
// Parameters
//   OVERSAMPLE  tick pulses per bit period (even, >= 4)
//   PARITY_EN   1 = one parity bit between the data bits and the stop bit
//   PARITY_ODD  1 = odd parity, 0 = even parity
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   rx_in       asynchronous serial input, idle high
//   tick        oversample enable, one-clk pulse
//   shift       one-clk pulse: downstream shift register captures rx_bit
//   rx_bit      sampled data bit, valid while shift=1 (LSB first)
//   rx_busy     high while a frame is being received
//   rx_done     one-clk pulse at the end of every completed frame
//   frame_err   stop bit was low in the last frame (held until next rx_done)
//   parity_err  parity mismatch in the last frame (held until next rx_done)

module uart_rx_ctrl #(
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_in,
    input  logic tick,
    output logic shift,
    output logic rx_bit,
    output logic rx_busy,
    output logic rx_done,
    output logic frame_err,
    output logic parity_err
);

    localparam int              TCW    = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TCW-1:0]  TC_MID = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0]  TC_END = TCW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t         state, state_nxt;
    logic [TCW-1:0] tick_cnt, tick_cnt_nxt;
    logic [2:0]     bit_cnt, bit_cnt_nxt;
    logic           par_acc, par_acc_nxt;   // running XOR of the data bits
    logic           par_bad, par_bad_nxt;   // parity verdict, published with rx_done
    logic           shift_nxt, rx_bit_nxt, done_nxt, ferr_nxt, perr_nxt;

    // Two-flop synchroniser. It resets to the idle (high) level, so a reset
    // release never looks like a start bit.
    logic rx_meta, rx_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            par_acc    <= 1'b0;
            par_bad    <= 1'b0;
            shift      <= 1'b0;
            rx_bit     <= 1'b0;
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            tick_cnt   <= tick_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            par_acc    <= par_acc_nxt;
            par_bad    <= par_bad_nxt;
            shift      <= shift_nxt;
            rx_bit     <= rx_bit_nxt;
            rx_done    <= done_nxt;
            frame_err  <= ferr_nxt;
            parity_err <= perr_nxt;
        end
    end

    // Pulses default low, so shift and rx_done last exactly one clk. Every
    // other piece of state holds unless a tick moves it.
    always_comb begin
        state_nxt    = state;
        tick_cnt_nxt = tick_cnt;
        bit_cnt_nxt  = bit_cnt;
        par_acc_nxt  = par_acc;
        par_bad_nxt  = par_bad;
        shift_nxt    = 1'b0;
        rx_bit_nxt   = rx_bit;
        done_nxt     = 1'b0;
        ferr_nxt     = frame_err;
        perr_nxt     = parity_err;

        if (tick) begin
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_nxt    = START;
                        tick_cnt_nxt = '0;
                    end
                end
                START: begin
                    // Check the start bit again at its midpoint. If the line
                    // is high again, the low level was a glitch.
                    if (tick_cnt == TC_MID) begin
                        tick_cnt_nxt = '0;
                        if (!rx_s) begin
                            state_nxt   = DATA;
                            bit_cnt_nxt = '0;
                            par_acc_nxt = 1'b0;
                            par_bad_nxt = 1'b0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        tick_cnt_nxt = tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    // From the start-bit midpoint, each full bit period lands
                    // on the middle of the next data bit.
                    if (tick_cnt == TC_END) begin
                        tick_cnt_nxt = '0;
                        shift_nxt    = 1'b1;
                        rx_bit_nxt   = rx_s;
                        par_acc_nxt  = par_acc ^ rx_s;
                        if (bit_cnt == 3'd7) begin
                            if (PARITY_EN) state_nxt = PARITY;
                            else           state_nxt = STOP;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_cnt_nxt = tick_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (tick_cnt == TC_END) begin
                        tick_cnt_nxt = '0;
                        par_bad_nxt  = par_acc ^ rx_s ^ PARITY_ODD;
                        state_nxt    = STOP;
                    end else begin
                        tick_cnt_nxt = tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt == TC_END) begin
                        tick_cnt_nxt = '0;
                        done_nxt     = 1'b1;
                        ferr_nxt     = ~rx_s;
                        perr_nxt     = PARITY_EN && par_bad;
                        // A low stop bit may be a line break. Wait for the
                        // line to go high before looking for a new start bit.
                        state_nxt    = rx_s ? IDLE : BREAK;
                    end else begin
                        tick_cnt_nxt = tick_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign rx_busy = (state == START) || (state == DATA) ||
                     (state == PARITY) || (state == STOP);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl.
// Two instances run here:
//   dut 0: OVERSAMPLE=16, no parity
//   dut 1: OVERSAMPLE=8, even parity
// Each instance has its own serial line and shares clk, reset and tick. Only
// one line carries a frame at any time.
// When the driver sends a frame, it queues the data bits it expects (LSB
// first) and the expected end-of-frame status. A monitor runs on every falling
// edge and compares each shift and rx_done pulse against those queues. The
// monitor also checks:
//   - the tick spacing between shift pulses and from the last shift to rx_done
//   - that frame_err and parity_err hold their values between frames

module tb_uart_rx_ctrl;

    localparam int OS0  = 16;
    localparam int OS1  = 8;
    localparam bit PODD = 1'b0;

    typedef struct {
        bit ferr;
        bit perr;
    } done_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick = 1'b0;
    logic rx_line [2];
    logic shift_o [2];
    logic rx_bit_o [2];
    logic busy_o [2];
    logic done_o [2];
    logic ferr_o [2];
    logic perr_o [2];

    int errors = 0;
    int checks = 0;
    int tick_div = 1;
    int tcnt = 0;

    bit    exp_bits[$];
    done_t exp_done[$];
    int    exp_shifts = 0;
    int    exp_dones  = 0;
    int    shift_cnt  = 0;
    int    done_cnt   = 0;

    int         gap [2];
    int         nsh [2];
    bit         last_ferr [2];
    bit         last_perr [2];
    logic [7:0] obs_byte [2];

    uart_rx_ctrl #(.OVERSAMPLE(OS0), .PARITY_EN(1'b0), .PARITY_ODD(PODD)) dut0 (
        .clk(clk), .reset(reset), .rx_in(rx_line[0]), .tick(tick),
        .shift(shift_o[0]), .rx_bit(rx_bit_o[0]), .rx_busy(busy_o[0]),
        .rx_done(done_o[0]), .frame_err(ferr_o[0]), .parity_err(perr_o[0])
    );

    uart_rx_ctrl #(.OVERSAMPLE(OS1), .PARITY_EN(1'b1), .PARITY_ODD(PODD)) dut1 (
        .clk(clk), .reset(reset), .rx_in(rx_line[1]), .tick(tick),
        .shift(shift_o[1]), .rx_bit(rx_bit_o[1]), .rx_busy(busy_o[1]),
        .rx_done(done_o[1]), .frame_err(ferr_o[1]), .parity_err(perr_o[1])
    );

    always #5 clk = ~clk;

    function automatic int os_of(input int d);
        return (d == 0) ? OS0 : OS1;
    endfunction

    function automatic bit pe_of(input int d);
        return (d == 0) ? 1'b0 : 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // The tick for each rising edge is driven just after the previous edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tcnt++;
            if (tcnt >= tick_div) tcnt = 0;
            tick = (tcnt == 0);
        end
    end

    // Wait until n ticks have been consumed, then step off the clock edge.
    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (tick) k++;
        end
        #1;
    endtask

    // Send one frame: start bit, 8 data bits LSB first, an optional parity
    // bit, then the stop bit. The line is left at the stop-bit level.
    task automatic send_frame(input int d, input logic [7:0] data, input bit par, input bit stop);
        done_t e;
        int    os = os_of(d);
        for (int i = 0; i < 8; i++) exp_bits.push_back(data[i]);
        e.ferr = ~stop;
        e.perr = pe_of(d) ? ((^data) ^ par ^ PODD) : 1'b0;
        exp_done.push_back(e);
        exp_shifts += 8;
        exp_dones  += 1;
        rx_line[d] = 1'b0;
        wait_ticks(os);
        for (int i = 0; i < 8; i++) begin
            rx_line[d] = data[i];
            wait_ticks(os);
        end
        if (pe_of(d)) begin
            rx_line[d] = par;
            wait_ticks(os);
        end
        rx_line[d] = stop;
        wait_ticks(os);
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s dut%0d shift", tag, d), shift_o[d], 0);
            chk($sformatf("%s dut%0d rx_bit", tag, d), rx_bit_o[d], 0);
            chk($sformatf("%s dut%0d rx_busy", tag, d), busy_o[d], 0);
            chk($sformatf("%s dut%0d rx_done", tag, d), done_o[d], 0);
            chk($sformatf("%s dut%0d frame_err", tag, d), ferr_o[d], 0);
            chk($sformatf("%s dut%0d parity_err", tag, d), perr_o[d], 0);
        end
    endtask

    // Monitor: compares every shift and rx_done pulse against the queued
    // expectations. It also checks the held error flags on every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                gap[d]       = 0;
                nsh[d]       = 0;
                last_ferr[d] = 1'b0;
                last_perr[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (shift_o[d]) begin
                    chk($sformatf("dut%0d busy during shift", d), busy_o[d], 1);
                    if (nsh[d] > 0)
                        chk($sformatf("dut%0d shift spacing", d), gap[d], os_of(d));
                    if (exp_bits.size() == 0) begin
                        chk($sformatf("dut%0d unexpected shift", d), 1, 0);
                    end else begin
                        chk($sformatf("dut%0d rx_bit", d), rx_bit_o[d], exp_bits.pop_front());
                    end
                    obs_byte[d] = {rx_bit_o[d], obs_byte[d][7:1]};
                    nsh[d]++;
                    shift_cnt++;
                    gap[d] = 0;
                end
                if (done_o[d]) begin
                    chk($sformatf("dut%0d shift count at done", d), nsh[d], 8);
                    chk($sformatf("dut%0d last shift to done", d), gap[d], os_of(d) * (1 + int'(pe_of(d))));
                    chk($sformatf("dut%0d busy at done", d), busy_o[d], 0);
                    if (exp_done.size() == 0) begin
                        chk($sformatf("dut%0d unexpected done", d), 1, 0);
                    end else begin
                        done_t e;
                        e = exp_done.pop_front();
                        last_ferr[d] = e.ferr;
                        last_perr[d] = e.perr;
                    end
                    done_cnt++;
                    nsh[d] = 0;
                    gap[d] = 0;
                end
                chk($sformatf("dut%0d frame_err", d), ferr_o[d], last_ferr[d]);
                chk($sformatf("dut%0d parity_err", d), perr_o[d], last_perr[d]);
                if (tick) gap[d]++;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         s0, d0, d;
        logic [7:0] data, pdata;
        bit         par, stop;

        for (int i = 0; i < 2; i++) begin
            rx_line[i]  = 1'b1;
            obs_byte[i] = 8'h00;
        end

        // Reset state
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        wait_ticks(4);

        // 0xA5 with a good stop bit; tick on every clk
        s0 = shift_cnt; d0 = done_cnt;
        send_frame(0, 8'hA5, 1'b0, 1'b1);
        chk("A5 shift count", shift_cnt - s0, 8);
        chk("A5 done count", done_cnt - d0, 1);
        chk("A5 byte", obs_byte[0], 8'hA5);
        chk("A5 frame_err", ferr_o[0], 0);
        wait_ticks(3);

        // Glitch: line low for only 5 ticks
        s0 = shift_cnt; d0 = done_cnt;
        rx_line[0] = 1'b0;
        wait_ticks(5);
        chk("glitch busy high", busy_o[0], 1);
        rx_line[0] = 1'b1;
        wait_ticks(16);
        chk("glitch busy dropped", busy_o[0], 0);
        chk("glitch no shift", shift_cnt - s0, 0);
        chk("glitch no done", done_cnt - d0, 0);

        // Break: 0x3C with a low stop bit; line held low 40 ticks in total
        d0 = done_cnt;
        send_frame(0, 8'h3C, 1'b0, 1'b0);
        chk("break frame_err set", ferr_o[0], 1);
        wait_ticks(40 - OS0);
        chk("break busy low", busy_o[0], 0);
        chk("break single done", done_cnt - d0, 1);
        rx_line[0] = 1'b1;
        wait_ticks(4);
        send_frame(0, 8'h55, 1'b0, 1'b1);
        chk("55 byte", obs_byte[0], 8'h55);
        chk("55 clears frame_err", ferr_o[0], 0);
        wait_ticks(2);

        // Parity (dut 1, even): 0xA5 has four ones
        send_frame(1, 8'hA5, 1'b1, 1'b1);
        chk("parity bit 1 -> error", perr_o[1], 1);
        chk("parity frame_err", ferr_o[1], 0);
        send_frame(1, 8'hA5, 1'b0, 1'b1);
        chk("parity bit 0 -> ok", perr_o[1], 0);
        chk("parity byte", obs_byte[1], 8'hA5);
        wait_ticks(2);

        // Reset after the 4th shift of a frame
        pdata = 8'hC6;
        s0 = shift_cnt; d0 = done_cnt;
        for (int i = 0; i < 4; i++) exp_bits.push_back(pdata[i]);
        exp_shifts += 4;
        rx_line[0] = 1'b0;
        wait_ticks(OS0);
        for (int i = 0; i < 4; i++) begin
            rx_line[0] = pdata[i];
            wait_ticks(OS0);
        end
        chk("pre-reset shifts", shift_cnt - s0, 4);
        reset = 1'b0;
        rx_line[0] = 1'b1;
        #1;
        check_all_zero("mid-frame reset");
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset held");
        chk("reset no done", done_cnt - d0, 0);
        exp_bits.delete();
        reset = 1'b1;
        wait_ticks(4);
        s0 = shift_cnt;
        send_frame(0, 8'h0F, 1'b0, 1'b1);
        chk("0F shifts after reset", shift_cnt - s0, 8);
        chk("0F byte", obs_byte[0], 8'h0F);
        chk("0F done after reset", done_cnt - d0, 1);

        // Back-to-back frames with a tick every 3 clk
        tick_div = 3;
        wait_ticks(2);
        s0 = shift_cnt; d0 = done_cnt;
        send_frame(0, 8'h81, 1'b0, 1'b1);
        chk("81 byte", obs_byte[0], 8'h81);
        send_frame(0, 8'h7E, 1'b0, 1'b1);
        chk("b2b shift count", shift_cnt - s0, 16);
        chk("b2b done count", done_cnt - d0, 2);
        chk("7E byte", obs_byte[0], 8'h7E);

        // Randomized frames on both lines
        for (int it = 0; it < 24; it++) begin
            d        = $urandom_range(0, 1);
            data     = 8'($urandom);
            par      = 1'($urandom_range(0, 1));
            stop     = ($urandom_range(0, 3) != 0);
            tick_div = $urandom_range(1, 3);
            send_frame(d, data, par, stop);
            chk("random byte", obs_byte[d], data);
            if (!stop) begin
                wait_ticks($urandom_range(0, 20));
                rx_line[d] = 1'b1;
                wait_ticks($urandom_range(3, 6));
            end else begin
                wait_ticks($urandom_range(0, 3));
            end
        end

        wait_ticks(40);
        chk("pending shifts", exp_bits.size(), 0);
        chk("pending dones", exp_done.size(), 0);
        chk("total shifts", shift_cnt, exp_shifts);
        chk("total dones", done_cnt, exp_dones);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
